// File: rtl/dcache_port_arbiter_if.sv
// Request/response bus between the data-cache port arbiter and the dcache.
// The arbiter is the master (issues requests); the cache is the slave.
interface dcache_port_arbiter_if;
    logic        dc_req;
    logic        dc_wr;
    logic [1:0]  dc_size;
    logic [3:0]  dc_wstrb;
    logic [31:0] dc_addr;
    logic [31:0] dc_wdata;
    logic        dc_addr_ok;
    logic        dc_data_ok;
    logic [31:0] dc_rdata;

    modport master (
        output dc_req, dc_wr, dc_size, dc_wstrb, dc_addr, dc_wdata,
        input  dc_addr_ok, dc_data_ok, dc_rdata
    );

    modport slave (
        input  dc_req, dc_wr, dc_size, dc_wstrb, dc_addr, dc_wdata,
        output dc_addr_ok, dc_data_ok, dc_rdata
    );
endinterface

// File: rtl/dcache_port_arbiter.sv
// Shares one dcache port between the two MEM pipeline paths: fixed-priority grant held
// until accepted, in-order owner/drop tag FIFO to route or discard responses.
module dcache_port_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  p0_req,
    input  logic                  p1_req,
    input  logic                  p0_wr,
    input  logic                  p1_wr,
    input  logic [1:0]            p0_size,
    input  logic [1:0]            p1_size,
    input  logic [3:0]            p0_wstrb,
    input  logic [3:0]            p1_wstrb,
    input  logic [31:0]           p0_addr,
    input  logic [31:0]           p1_addr,
    input  logic [31:0]           p0_wdata,
    input  logic [31:0]           p1_wdata,
    output logic                  p0_addr_ok,
    output logic                  p1_addr_ok,
    output logic                  p0_data_ok,
    output logic                  p1_data_ok,
    output logic [31:0]           p_rdata,
    input  logic                  flush,
    dcache_port_arbiter_if.master dc,
    output logic                  busy,
    output logic                  proto_err
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, HOLD0, HOLD1} state_t;

    state_t           state;
    logic             hold_flushed;
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [PTR_W:0]   count;
    logic [DEPTH-1:0] owner_q, drop_q, valid;
    logic             grant_act, grant_sel, full, push, pop, push_drop;

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        grant_act = 1'b0;
        grant_sel = 1'b0;
        unique case (state)
            IDLE: begin
                grant_act = p0_req | p1_req;
                grant_sel = !p0_req;
            end
            HOLD0: grant_act = 1'b1;
            HOLD1: begin
                grant_act = 1'b1;
                grant_sel = 1'b1;
            end
            default: ;
        endcase
    end

    assign full      = (count == (PTR_W+1)'(DEPTH));
    assign dc.dc_req = grant_act & !full & !((state == IDLE) & flush);

    always_comb begin
        dc.dc_wr    = 1'b0;
        dc.dc_size  = '0;
        dc.dc_wstrb = '0;
        dc.dc_addr  = '0;
        dc.dc_wdata = '0;
        if (dc.dc_req) begin
            dc.dc_wr    = grant_sel ? p1_wr    : p0_wr;
            dc.dc_size  = grant_sel ? p1_size  : p0_size;
            dc.dc_wstrb = grant_sel ? p1_wstrb : p0_wstrb;
            dc.dc_addr  = grant_sel ? p1_addr  : p0_addr;
            dc.dc_wdata = grant_sel ? p1_wdata : p0_wdata;
        end
    end

    assign push       = dc.dc_req & dc.dc_addr_ok;
    assign pop        = dc.dc_data_ok & (count != '0);
    assign push_drop  = flush | hold_flushed;
    assign p0_addr_ok = push & !grant_sel;
    assign p1_addr_ok = push & grant_sel;
    assign p0_data_ok = pop & !owner_q[rd_ptr] & !drop_q[rd_ptr];
    assign p1_data_ok = pop & owner_q[rd_ptr] & !drop_q[rd_ptr];
    assign p_rdata    = dc.dc_rdata;
    assign busy       = (count != '0) | (state != IDLE);

    // Entry i is live when its distance from the head is below the occupancy.
    always_comb begin
        valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [PTR_W-1:0] offs;
            offs     = PTR_W'(i) - rd_ptr;
            valid[i] = ({1'b0, offs} < count);
        end
    end

    // NOTE: sequential state is assigned with <= only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            hold_flushed <= 1'b0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            drop_q       <= '0;
            proto_err    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (dc.dc_req && !dc.dc_addr_ok) state <= grant_sel ? HOLD1 : HOLD0;
                HOLD0, HOLD1: begin
                    if (push) begin
                        state        <= IDLE;
                        hold_flushed <= 1'b0;
                    end else if (flush) begin
                        hold_flushed <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
            if (flush) drop_q <= drop_q | valid;
            if (push) begin
                drop_q[wr_ptr] <= push_drop;
                wr_ptr         <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
            if (dc.dc_data_ok && count == '0) proto_err <= 1'b1;
        end
    end

    // NOTE: owner storage is not reset; an entry is only read while count marks it live.
    always_ff @(posedge clk) begin
        if (push) owner_q[wr_ptr] <= grant_sel;
    end
endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Directed bench for dcache_port_arbiter: grant priority and lock, full stall,
// flush drop handling, and spurious-response detection.
module tb_dcache_port_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        p0_req, p1_req, p0_wr, p1_wr, flush;
    logic [1:0]  p0_size, p1_size;
    logic [3:0]  p0_wstrb, p1_wstrb;
    logic [31:0] p0_addr, p1_addr, p0_wdata, p1_wdata, p_rdata;
    logic        p0_addr_ok, p1_addr_ok, p0_data_ok, p1_data_ok, busy, proto_err;
    int          checks = 0;
    int          failures = 0;

    dcache_port_arbiter_if bus ();

    dcache_port_arbiter #(.DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .p0_req     (p0_req),
        .p1_req     (p1_req),
        .p0_wr      (p0_wr),
        .p1_wr      (p1_wr),
        .p0_size    (p0_size),
        .p1_size    (p1_size),
        .p0_wstrb   (p0_wstrb),
        .p1_wstrb   (p1_wstrb),
        .p0_addr    (p0_addr),
        .p1_addr    (p1_addr),
        .p0_wdata   (p0_wdata),
        .p1_wdata   (p1_wdata),
        .p0_addr_ok (p0_addr_ok),
        .p1_addr_ok (p1_addr_ok),
        .p0_data_ok (p0_data_ok),
        .p1_data_ok (p1_data_ok),
        .p_rdata    (p_rdata),
        .flush      (flush),
        .dc         (bus.master),
        .busy       (busy),
        .proto_err  (proto_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic idle_in();
        p0_req = 0; p1_req = 0; p0_wr = 0; p1_wr = 0;
        p0_size = 0; p1_size = 0; p0_wstrb = 0; p1_wstrb = 0;
        p0_addr = 0; p1_addr = 0; p0_wdata = 0; p1_wdata = 0;
        flush = 0;
        bus.dc_addr_ok = 0; bus.dc_data_ok = 0; bus.dc_rdata = 0;
    endtask

    task automatic drive0(input logic [31:0] a);
        p0_req = 1; p0_wr = 0; p0_size = 2'd2; p0_wstrb = 4'h0; p0_addr = a; p0_wdata = 0;
    endtask

    task automatic drive1(input logic [31:0] a);
        p1_req = 1; p1_wr = 1; p1_size = 2'd2; p1_wstrb = 4'hF; p1_addr = a; p1_wdata = ~a;
    endtask

    // Inputs change just after a negedge; outputs are sampled 1ns later.
    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        idle_in();
        reset = 1;
        repeat (2) cyc();
        #1;
        check("rst_dc_req", bus.dc_req, 0);
        check("rst_busy", busy, 0);
        check("rst_proto_err", proto_err, 0);
        check("rst_data_ok", {p0_data_ok, p1_data_ok, p0_addr_ok, p1_addr_ok}, 0);
        cyc(); reset = 0;

        // Simultaneous request: path 0 first, then path 1; responses in order.
        cyc(); drive0(32'h1000); drive1(32'h2000); bus.dc_addr_ok = 1; #1;
        check("sim_c0_dc_req", bus.dc_req, 1);
        check("sim_c0_dc_addr", bus.dc_addr, 32'h1000);
        check("sim_c0_addr_ok", {p0_addr_ok, p1_addr_ok}, 2'b10);
        cyc(); p0_req = 0; #1;
        check("sim_c1_dc_addr", bus.dc_addr, 32'h2000);
        check("sim_c1_dc_wr", bus.dc_wr, 1);
        check("sim_c1_dc_wdata", bus.dc_wdata, ~32'h2000);
        check("sim_c1_dc_wstrb", bus.dc_wstrb, 4'hF);
        check("sim_c1_addr_ok", {p0_addr_ok, p1_addr_ok}, 2'b01);
        cyc(); idle_in(); bus.dc_data_ok = 1; bus.dc_rdata = 32'hAAAA_0000; #1;
        check("sim_r0_data_ok", {p0_data_ok, p1_data_ok}, 2'b10);
        check("sim_r0_rdata", p_rdata, 32'hAAAA_0000);
        cyc(); bus.dc_rdata = 32'hBBBB_1111; #1;
        check("sim_r1_data_ok", {p0_data_ok, p1_data_ok}, 2'b01);
        cyc(); idle_in(); #1;
        check("sim_idle_busy", busy, 0);

        // Grant lock: path 1 held three cycles while path 0 arrives.
        cyc(); drive1(32'h2100); #1;
        check("lock_c0_dc_addr", bus.dc_addr, 32'h2100);
        check("lock_c0_addr_ok", {p0_addr_ok, p1_addr_ok}, 2'b00);
        cyc(); drive0(32'h1100); #1;
        check("lock_c1_dc_addr", bus.dc_addr, 32'h2100);
        check("lock_c1_busy", busy, 1);
        cyc(); #1;
        check("lock_c2_dc_addr", bus.dc_addr, 32'h2100);
        cyc(); bus.dc_addr_ok = 1; #1;
        check("lock_c3_dc_addr", bus.dc_addr, 32'h2100);
        check("lock_c3_addr_ok", {p0_addr_ok, p1_addr_ok}, 2'b01);
        cyc(); p1_req = 0; #1;
        check("lock_c4_dc_addr", bus.dc_addr, 32'h1100);
        check("lock_c4_addr_ok", {p0_addr_ok, p1_addr_ok}, 2'b10);
        cyc(); idle_in(); bus.dc_data_ok = 1; #1;
        check("lock_r0_data_ok", {p0_data_ok, p1_data_ok}, 2'b01);
        cyc(); #1;
        check("lock_r1_data_ok", {p0_data_ok, p1_data_ok}, 2'b10);

        // Full: four accepted, fifth stalls until one slot frees.
        for (int k = 0; k < 4; k++) begin
            cyc(); idle_in(); drive0(32'h3000 + 32'(k) * 4); bus.dc_addr_ok = 1; #1;
            check($sformatf("full_acc%0d", k), p0_addr_ok, 1);
        end
        cyc(); drive0(32'h3010); #1;
        check("full_dc_req", bus.dc_req, 0);
        check("full_addr_ok", p0_addr_ok, 0);
        check("full_busy", busy, 1);
        cyc(); bus.dc_data_ok = 1; #1;
        check("full_pop_dc_req", bus.dc_req, 0);
        check("full_pop_data_ok", p0_data_ok, 1);
        cyc(); bus.dc_data_ok = 0; #1;
        check("full_next_dc_req", bus.dc_req, 1);
        check("full_next_dc_addr", bus.dc_addr, 32'h3010);
        check("full_next_addr_ok", p0_addr_ok, 1);
        for (int k = 0; k < 4; k++) begin
            cyc(); idle_in(); bus.dc_data_ok = 1; #1;
            check($sformatf("full_drain%0d", k), {p0_data_ok, p1_data_ok}, 2'b10);
        end
        cyc(); idle_in(); #1;
        check("full_end_busy", busy, 0);

        // Flush: head popped during flush still delivered; the rest discarded.
        cyc(); drive0(32'h4000); drive1(32'h4100); bus.dc_addr_ok = 1; #1;
        check("fl_acc0", p0_addr_ok, 1);
        cyc(); p0_req = 0; #1;
        check("fl_acc1", p1_addr_ok, 1);
        cyc(); p1_req = 0; drive0(32'h4200); #1;
        check("fl_acc2", p0_addr_ok, 1);
        cyc(); idle_in(); drive0(32'h4300); flush = 1; bus.dc_data_ok = 1; #1;
        check("fl_idle_dc_req", bus.dc_req, 0);
        check("fl_same_cycle_pop", {p0_data_ok, p1_data_ok}, 2'b10);
        cyc(); idle_in(); bus.dc_data_ok = 1; #1;
        check("fl_drop0", {p0_data_ok, p1_data_ok}, 2'b00);
        cyc(); #1;
        check("fl_drop1", {p0_data_ok, p1_data_ok}, 2'b00);
        cyc(); idle_in(); drive1(32'h4400); bus.dc_addr_ok = 1; #1;
        check("fl_new_acc", p1_addr_ok, 1);
        cyc(); idle_in(); bus.dc_data_ok = 1; #1;
        check("fl_new_resp", {p0_data_ok, p1_data_ok}, 2'b01);

        // Flush during HOLD0: request kept, entry pushed dropped, FSM back to IDLE.
        cyc(); idle_in(); drive0(32'h5000); #1;
        check("hf_c0_dc_req", bus.dc_req, 1);
        cyc(); flush = 1; drive1(32'h5100); #1;
        check("hf_c1_dc_req", bus.dc_req, 1);
        check("hf_c1_dc_addr", bus.dc_addr, 32'h5000);
        cyc(); flush = 0; p1_req = 0; bus.dc_addr_ok = 1; #1;
        check("hf_c2_addr_ok", p0_addr_ok, 1);
        cyc(); idle_in(); bus.dc_data_ok = 1; #1;
        check("hf_busy", busy, 1);
        check("hf_resp_dropped", {p0_data_ok, p1_data_ok}, 2'b00);
        cyc(); idle_in(); #1;
        check("hf_idle_busy", busy, 0);

        // Spurious response with empty FIFO.
        cyc(); bus.dc_data_ok = 1; #1;
        check("sp_data_ok", {p0_data_ok, p1_data_ok}, 2'b00);
        cyc(); bus.dc_data_ok = 0; #1;
        check("sp_proto_err", proto_err, 1);
        cyc(); #1;
        check("sp_proto_err_sticky", proto_err, 1);
        cyc(); reset = 1;
        cyc(); reset = 0; #1;
        check("sp_proto_err_reset", proto_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
